vector_sequencer: RTL
=====================

Name: vector_sequencer

Overview:
- Synthesizable, parametrised stimulus sequencer: plays a stored program of vectors onto a VEC_W-bit output bus, one vector per step.
- Generalises the fixed program-counter/opcode-ROM scheme:
  - loadable memory;
  - per-vector hold count;
  - programmable length;
  - loop mode with loop counter;
  - pause/stop control.
- Sits between a host/load interface and the DUT input pins in on-chip test harnesses.

Parameters:
- VEC_W, 11, width of the vector driven onto vec_out
- DEPTH, 256, number of program entries
- AW, 8, address width (clog2(DEPTH))
- HOLD_W, 4, width of per-entry hold field
- CNT_W, 16, width of loop counter

Ports:
- sys_clk  in  1  clock, rising edge
- sys_rst_l  in  1  asynchronous active-low reset
- ld_we  in  1  program memory write enable
- ld_addr  in  AW  write address
- ld_data  in  HOLD_W+VEC_W  entry: [HOLD_W+VEC_W-1:VEC_W]=hold, [VEC_W-1:0]=vector
- start  in  1  begin playback (single-cycle pulse)
- stop  in  1  abort playback
- pause  in  1  freeze playback while high
- loop_en  in  1  wrap to entry 0 after last entry
- len_m1  in  AW  index of last entry to play
- vec_out  out  VEC_W  current vector
- vec_valid  out  1  vec_out is an active, unpaused vector
- pc  out  AW  index of entry currently on vec_out
- busy  out  1  sequencer not idle
- done  out  1  one-cycle pulse on normal completion
- loop_cnt  out  CNT_W  completed wraps, saturating

Behaviour:
Reset:
- Asserting sys_rst_l low, at any time including mid-run, immediately forces:
  - vec_out=0, vec_valid=0, pc=0, busy=0, done=0, loop_cnt=0;
  - state IDLE; internal hold counter 0.
- Memory contents are not reset.

States: IDLE, FETCH, RUN.

Load:
- ld_we is honoured only when busy=0 and writes ld_data to ld_addr.
- When busy=1, ld_we is ignored.
- Memory read is synchronous, 1-cycle latency.

Start (IDLE):
- start=1 and stop=0 at edge T:
  - latch len_m1 into len_r;
  - loop_cnt<=0, pc<=0, busy<=1;
  - enter FETCH.
- Entry 0 appears on vec_out with vec_valid=1 from edge T+2 (state RUN).
- start while busy=1 is ignored.

Hold:
- Entry with hold field h stays on vec_out for exactly h+1 cycles.
- Successive entries follow back-to-back, no gap cycles, with pc tracking the displayed entry.
- The memory read for the next entry is prefetched during the current entry.

End of program (last cycle of entry len_r):
- loop_en=1 (sampled that cycle):
  - next cycle shows entry 0, pc=0, no gap;
  - loop_cnt increments, saturating at all-ones.
- loop_en=0:
  - next cycle vec_out=0, vec_valid=0, busy=0;
  - done=1 for one cycle; return to IDLE; pc holds len_r.

len_m1=0:
- Single-entry program.
- With loop_en=1, entry 0 repeats indefinitely and loop_cnt increments every h+1 cycles.

Pause:
- While pause=1 in RUN:
  - pc, hold counter and vec_out are frozen;
  - vec_valid=0.
- On release, playback resumes with vec_valid=1 and the remaining hold cycles intact.
- pause in FETCH delays the transition to RUN.

Stop:
- Highest priority.
- stop=1 in FETCH or RUN: next cycle IDLE, vec_out=0, vec_valid=0, busy=0, done stays 0.
- loop_cnt keeps its value; pc keeps its value.
- start and stop together in IDLE: stop wins, remain IDLE.

Priority (per cycle): reset > stop > pause > start/advance.

Out-of-range:
- len_m1 >= DEPTH is clamped to DEPTH-1 when latched.

Test Plan:
- Load entries 0..3 = {hold 0, vec 0x001,0x002,0x004,0x008}, len_m1=3, loop_en=0, pulse start at T -> vec_out 0x001,0x002,0x004,0x008 on T+2..T+5, pc 0..3, vec_valid=1 throughout. Then vec_valid=0, vec_out=0, done=1 at T+6 only, busy=0.
- Entry 1 hold=3, others hold=0 -> 0x002 held 4 consecutive cycles, total run 7 cycles, no gaps.
- loop_en=1, len_m1=1, holds 0 -> output alternates 0x001/0x002, loop_cnt increments each 2 cycles. With CNT_W forced to 2, loop_cnt saturates at 3.
- Pause 3 cycles mid-hold of a hold=3 entry after its 2nd cycle -> vec_valid low 3 cycles, vec_out frozen, then 2 more valid cycles of same vector.
- stop asserted during entry 2 -> next cycle vec_out=0, busy=0, done never pulses. ld_we issued during run leaves memory unchanged (verified by replay).
- Async reset pulse mid-run, between clock edges -> all outputs zero immediately. A subsequent start replays the original memory contents correctly.

Source files
------------

// File: rtl/vector_sequencer.sv
// Plays a loaded program of held vectors onto vec_out; entry 0 shows two cycles after start.
// No backpressure: pause freezes playback in place, stop aborts to idle on the next edge.
module vector_sequencer #(
    parameter int VEC_W  = 11,
    parameter int DEPTH  = 256,
    parameter int AW     = 8,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_l,
    input  logic                    ld_we,
    input  logic [AW-1:0]           ld_addr,
    input  logic [HOLD_W+VEC_W-1:0] ld_data,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    pause,
    input  logic                    loop_en,
    input  logic [AW-1:0]           len_m1,
    output logic [VEC_W-1:0]        vec_out,
    output logic                    vec_valid,
    output logic [AW-1:0]           pc,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        loop_cnt
);
    localparam int EW = HOLD_W + VEC_W;
    localparam int unsigned LAST = DEPTH - 1;

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, RUN = 2'd2} state_t;

    state_t              state_q, state_d;
    logic                fetch_ph_q, fetch_ph_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic [AW-1:0]       len_q, len_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]       len_clamped;
    logic [AW-1:0]       rd_addr;
    logic [EW-1:0]       rd_q;
    logic [EW-1:0]       mem [DEPTH];

    // rd_q always holds the entry that the next advance will display
    always_ff @(posedge sys_clk) begin
        if (ld_we && state_q == IDLE) begin
            mem[ld_addr] <= ld_data;
        end
        rd_q <= mem[rd_addr];
    end

    always_comb begin
        len_clamped = len_m1;
        if (32'(len_m1) > LAST) begin
            len_clamped = AW'(LAST);
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_ph_d = fetch_ph_q;
        pc_d       = pc_q;
        len_d      = len_q;
        hold_d     = hold_q;
        vec_d      = vec_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        rd_addr    = '0;

        case (state_q)
            IDLE: begin
                if (start && !stop && !pause) begin
                    state_d    = FETCH;
                    fetch_ph_d = 1'b0;
                    pc_d       = '0;
                    cnt_d      = '0;
                    len_d      = len_clamped;
                end
            end
            FETCH: begin
                if (stop) begin
                    state_d = IDLE;
                    vec_d   = '0;
                    hold_d  = '0;
                end else if (!pause) begin
                    if (!fetch_ph_q) begin
                        fetch_ph_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        pc_d    = '0;
                        vec_d   = rd_q[VEC_W-1:0];
                        hold_d  = rd_q[EW-1:VEC_W];
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    vec_d   = '0;
                    hold_d  = '0;
                end else if (!pause) begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - HOLD_W'(1);
                    end else if (pc_q == len_q && !loop_en) begin
                        state_d = IDLE;
                        vec_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        pc_d   = (pc_q == len_q) ? '0 : pc_q + AW'(1);
                        vec_d  = rd_q[VEC_W-1:0];
                        hold_d = rd_q[EW-1:VEC_W];
                        if (pc_q == len_q && cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == RUN) begin
            rd_addr = (pc_d == len_d) ? '0 : pc_d + AW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_q    <= IDLE;
            fetch_ph_q <= 1'b0;
            pc_q       <= '0;
            len_q      <= '0;
            hold_q     <= '0;
            vec_q      <= '0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_ph_q <= fetch_ph_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            hold_q     <= hold_d;
            vec_q      <= vec_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    assign vec_out   = vec_q;
    assign vec_valid = (state_q == RUN) && !pause;
    assign pc        = pc_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign loop_cnt  = cnt_q;
endmodule
